// File: rtl/tree_walk_engine_pkg.sv
// Shared definitions for the tree walk engine: FSM state encoding, SRAM word
// field offsets and the leaf-base address expression.
package tree_walk_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LEAF_FETCH,
    ST_LEAF_WAIT,
    ST_DONE
  } twe_state_e;

  // SRAM word layout is {fidx, hi_field, lo_field}, lo_field at bit 0.
  localparam int LO_LSB = 0;

  function automatic int hi_lsb(input int feat_w);
    return feat_w;
  endfunction

  function automatic int fidx_lsb(input int feat_w);
    return 2 * feat_w;
  endfunction

  // First leaf address; leaves fill 2^depth-1 .. 2^(depth+1)-2.
  function automatic int leaf_base(input int depth);
    return (1 << depth) - 1;
  endfunction

endpackage

// File: rtl/tree_walk_engine_if.sv
// Sample, SRAM read and result ports of the tree walk engine.
// Optional: TREE_PATH_TRACE_EN adds the m_path result field.
interface tree_walk_engine_if #(
  parameter int DEPTH    = 2,
  parameter int NUM_FEAT = 4,
  parameter int FEAT_W   = 8,
  parameter int FIDX_W   = 2
);
  localparam int ADDR_W = DEPTH + 1;
  localparam int MEM_W  = FIDX_W + 2 * FEAT_W;

  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_FEAT*FEAT_W-1:0] s_data;

  logic                       mem_rd_en;
  logic [ADDR_W-1:0]          mem_addr;
  logic                       mem_rd_valid;
  logic [MEM_W-1:0]           mem_rd_data;

  logic                       m_valid;
  logic                       m_ready;
  logic [2*FEAT_W-1:0]        m_result;
  logic [DEPTH-1:0]           m_leaf;
  logic                       m_err;
`ifdef TREE_PATH_TRACE_EN
  logic [DEPTH-1:0]           m_path;
`endif

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output mem_rd_en, mem_addr,
    input  mem_rd_valid, mem_rd_data,
    output m_valid,
    input  m_ready,
    output m_result, m_leaf, m_err
`ifdef TREE_PATH_TRACE_EN
    , output m_path
`endif
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  mem_rd_en, mem_addr,
    output mem_rd_valid, mem_rd_data,
    input  m_valid,
    output m_ready,
    input  m_result, m_leaf, m_err
`ifdef TREE_PATH_TRACE_EN
    , input m_path
`endif
  );

endinterface

// File: rtl/tree_walk_engine_leaf_mac.sv
// leaf_mac: registered unsigned mult*feature+offset, full 2*FEAT_W result.
module leaf_mac #(
  parameter int FEAT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [FEAT_W-1:0]   i_mult,
  input  logic [FEAT_W-1:0]   i_feat,
  input  logic [FEAT_W-1:0]   i_off,
  output logic [2*FEAT_W-1:0] o_result
);

  logic [2*FEAT_W-1:0] w_mult_x;
  logic [2*FEAT_W-1:0] w_feat_x;
  logic [2*FEAT_W-1:0] w_off_x;
  logic [2*FEAT_W-1:0] r_result;

  assign w_mult_x = {{FEAT_W{1'b0}}, i_mult};
  assign w_feat_x = {{FEAT_W{1'b0}}, i_feat};
  assign w_off_x  = {{FEAT_W{1'b0}}, i_off};

  // (2^W-1)^2 + (2^W-1) < 2^(2W), so the sum never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (i_en) begin
      r_result <= w_mult_x * w_feat_x + w_off_x;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/tree_walk_engine.sv
// Walks one sample through a DEPTH-level binary decision tree held in SRAM,
// then scores the reached leaf. Optional: TREE_PATH_TRACE_EN adds m_path.
module tree_walk_engine #(
  parameter int DEPTH    = 2,
  parameter int NUM_FEAT = 4,
  parameter int FEAT_W   = 8,
  parameter int FIDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  tree_walk_engine_if.master bus
);
  import tree_walk_engine_pkg::*;

  localparam int ADDR_W   = DEPTH + 1;
  localparam int LVL_W    = 4;
  localparam int FIDX_LSB = fidx_lsb(FEAT_W);
  localparam int HI_LSB   = hi_lsb(FEAT_W);
  localparam logic [ADDR_W-1:0] LEAF_BASE = ADDR_W'(leaf_base(DEPTH));

  twe_state_e                 r_state;
  twe_state_e                 w_next;
  logic [NUM_FEAT*FEAT_W-1:0] r_sample;
  logic [ADDR_W-1:0]          r_node;
  logic [ADDR_W-1:0]          w_node_next;
  logic [LVL_W-1:0]           r_level;
  logic                       r_err;
  logic [DEPTH-1:0]           r_leaf;
`ifdef TREE_PATH_TRACE_EN
  logic [DEPTH-1:0]           r_path_acc;
  logic [DEPTH-1:0]           r_path;
`endif

  logic [FIDX_W-1:0]   w_fidx;
  logic [FEAT_W-1:0]   w_lo;
  logic [FEAT_W-1:0]   w_hi;
  logic [FEAT_W-1:0]   w_feat;
  logic                w_oob;
  logic                w_gt;
  logic                w_last;
  logic                w_node_rsp;
  logic                w_leaf_rsp;
  logic [2*FEAT_W-1:0] w_mac_result;

  assign w_fidx = bus.mem_rd_data[FIDX_LSB +: FIDX_W];
  assign w_hi   = bus.mem_rd_data[HI_LSB +: FEAT_W];
  assign w_lo   = bus.mem_rd_data[LO_LSB +: FEAT_W];

  // Indices with no matching feature read as 0 and flag the sample.
  always_comb begin
    w_feat = '0;
    w_oob  = 1'b1;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (w_fidx == FIDX_W'(k)) begin
        w_feat = r_sample[k*FEAT_W +: FEAT_W];
        w_oob  = 1'b0;
      end
    end
  end

  assign w_gt        = (w_feat > w_lo);
  assign w_last      = (r_level == LVL_W'(DEPTH - 1));
  assign w_node_next = {r_node[ADDR_W-2:0], 1'b0} + (w_gt ? ADDR_W'(1) : ADDR_W'(2));
  assign w_node_rsp  = (r_state == ST_WAIT) && bus.mem_rd_valid;
  assign w_leaf_rsp  = (r_state == ST_LEAF_WAIT) && bus.mem_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.s_ready   = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.m_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = r_node;
        w_next        = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rd_valid) w_next = w_last ? ST_LEAF_FETCH : ST_FETCH;
      end
      ST_LEAF_FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = r_node;
        w_next        = ST_LEAF_WAIT;
      end
      ST_LEAF_WAIT: begin
        if (bus.mem_rd_valid) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_node   <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      r_leaf   <= '0;
`ifdef TREE_PATH_TRACE_EN
      r_path_acc <= '0;
      r_path     <= '0;
`endif
    end else begin
      if (r_state == ST_IDLE && bus.s_valid) begin
        r_sample <= bus.s_data;
        r_node   <= '0;
        r_level  <= '0;
        r_err    <= 1'b0;
`ifdef TREE_PATH_TRACE_EN
        r_path_acc <= '0;
`endif
      end
      if (w_node_rsp) begin
        r_node <= w_node_next;
        r_err  <= r_err | w_oob;
        if (!w_last) r_level <= r_level + LVL_W'(1);
`ifdef TREE_PATH_TRACE_EN
        r_path_acc <= r_path_acc | (DEPTH'(w_gt) << r_level);
`endif
      end
      // Leaf capture lands on the same edge as the leaf_mac result register.
      if (w_leaf_rsp) begin
        r_err  <= r_err | w_oob;
        r_leaf <= DEPTH'(r_node - LEAF_BASE);
`ifdef TREE_PATH_TRACE_EN
        r_path <= r_path_acc;
`endif
      end
    end
  end

  leaf_mac #(
    .FEAT_W (FEAT_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_leaf_rsp),
    .i_mult   (w_hi),
    .i_feat   (w_feat),
    .i_off    (w_lo),
    .o_result (w_mac_result)
  );

  assign bus.m_result = w_mac_result;
  assign bus.m_leaf   = r_leaf;
  assign bus.m_err    = r_err;
`ifdef TREE_PATH_TRACE_EN
  assign bus.m_path   = r_path;
`endif

endmodule

// File: tb/tb_tree_walk_engine.sv
// Scoreboard bench for tree_walk_engine (DEPTH=2, NUM_FEAT=3) with a
// variable-latency SRAM model and a behavioural tree-walk reference.
module tb_tree_walk_engine;

  localparam int D      = 2;
  localparam int NF     = 3;
  localparam int FW     = 8;
  localparam int FXW    = 2;
  localparam int AW     = D + 1;
  localparam int MW     = FXW + 2 * FW;
  localparam int NWORDS = (1 << (D + 1)) - 1;

  typedef struct packed {
    logic [2*FW-1:0] res;
    logic [D-1:0]    leaf;
    logic            err;
    logic [D-1:0]    path;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tree_walk_engine_if #(.DEPTH(D), .NUM_FEAT(NF), .FEAT_W(FW), .FIDX_W(FXW)) bus ();

  tree_walk_engine #(
    .DEPTH    (D),
    .NUM_FEAT (NF),
    .FEAT_W   (FW),
    .FIDX_W   (FXW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [MW-1:0] mem [NWORDS];
  int            lat = 1;
  bit            pend = 1'b0;
  int            cnt = 0;
  logic [AW-1:0] paddr = '0;
  logic          rsp_valid = 1'b0;
  logic [MW-1:0] rsp_data = '0;
  logic          stray_valid = 1'b0;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  assign bus.mem_rd_valid = rsp_valid | stray_valid;
  assign bus.mem_rd_data  = stray_valid ? mem[0] : rsp_data;

  // SRAM model: data valid 'lat' cycles after the request cycle.
  always @(negedge clk) begin
    rsp_valid = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = mem[paddr];
        pend      = 1'b0;
      end
    end
    if (bus.mem_rd_en === 1'b1) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = bus.mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] word(input int fidx, input int hi, input int lo);
    return {FXW'(fidx), FW'(hi), FW'(lo)};
  endfunction

  function automatic exp_t model(input logic [NF*FW-1:0] smp);
    exp_t          e;
    int            n;
    int            fx;
    logic [MW-1:0] w;
    logic [FW-1:0] f;
    e = '0;
    n = 0;
    for (int lvl = 0; lvl <= D; lvl++) begin
      w  = mem[n];
      fx = int'(w[MW-1 -: FXW]);
      if (fx < NF) begin
        f = smp[fx*FW +: FW];
      end else begin
        f     = '0;
        e.err = 1'b1;
      end
      if (lvl < D) begin
        if (f > w[FW-1:0]) begin
          e.path[lvl] = 1'b1;
          n = 2 * n + 1;
        end else begin
          n = 2 * n + 2;
        end
      end else begin
        e.res  = 16'(w[2*FW-1:FW]) * 16'(f) + 16'(w[FW-1:0]);
        e.leaf = D'(n - ((1 << D) - 1));
      end
    end
    return e;
  endfunction

  function automatic logic [NF*FW-1:0] smp3(input int f0, input int f1, input int f2);
    return {FW'(f2), FW'(f1), FW'(f0)};
  endfunction

  task automatic load_s1();
    for (int i = 0; i < NWORDS; i++) mem[i] = '0;
    mem[0] = word(0, 0, 4);
    mem[1] = word(1, 0, 9);
    mem[2] = word(1, 0, 9);
    mem[4] = word(0, 8, 5);
    mem[6] = word(0, 8, 0);
  endtask

  task automatic run_sample(input logic [NF*FW-1:0] smp, input int l, input int stall,
                            input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   busy_ready;
    bit   unstable;
    lat          = l;
    bus.s_data   = smp;
    bus.s_valid  = 1'b1;
    cyc = 0;
    while (bus.s_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    sb.push_back(model(smp));
    cyc = 0;
    busy_ready = 1'b0;
    while (bus.m_valid !== 1'b1 && cyc < 200) begin
      if (bus.s_ready !== 1'b0) busy_ready = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'((D + 1) * (l + 1)));
    check({tag, "_sready_busy"}, 32'(busy_ready), 32'(0));
    got = '0;
    got.res  = bus.m_result;
    got.leaf = bus.m_leaf;
    got.err  = bus.m_err;
`ifdef TREE_PATH_TRACE_EN
    got.path = bus.m_path;
`endif
    unstable = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_result !== got.res ||
          bus.m_leaf !== got.leaf || bus.m_err !== got.err) unstable = 1'b1;
    end
    if (stall > 0) check({tag, "_stall_stable"}, 32'(unstable), 32'(0));
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(got.res), 32'(e.res));
      check({tag, "_leaf"}, 32'(got.leaf), 32'(e.leaf));
      check({tag, "_err"}, 32'(got.err), 32'(e.err));
`ifdef TREE_PATH_TRACE_EN
      check({tag, "_path"}, 32'(got.path), 32'(e.path));
`endif
    end
    check({tag, "_post_mvalid"}, 32'(bus.m_valid), 32'(0));
    check({tag, "_post_sready"}, 32'(bus.s_ready), 32'(1));
  endtask

  initial begin
    bit   bad;
    exp_t e;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    load_s1();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 32'(bus.s_ready), 32'(1));
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'(0));
    check("rst_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_mvalid", 32'(bus.m_valid), 32'(0));
    check("rst_result", 32'(bus.m_result), 32'(0));
    check("rst_leaf", 32'(bus.m_leaf), 32'(0));
    check("rst_err", 32'(bus.m_err), 32'(0));
`ifdef TREE_PATH_TRACE_EN
    check("rst_path", 32'(bus.m_path), 32'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: basic walk, then fixed expectations from hand calculation.
    e = model(smp3(8, 3, 0));
    check("s1_model_result", 32'(e.res), 32'h45);
    check("s1_model_leaf", 32'(e.leaf), 32'(1));
    run_sample(smp3(8, 3, 0), 1, 0, "s1");
`ifdef TREE_PATH_TRACE_EN
    check("s1_path_const", 32'(e.path), 32'(2'b01));
`endif

    mem[0] = word(0, 0, 8);
    e = model(smp3(8, 3, 0));
    check("eq_model_result", 32'(e.res), 32'h40);
    run_sample(smp3(8, 3, 0), 1, 0, "eq");

    load_s1();
    run_sample(smp3(8, 3, 0), 3, 4, "lat3");

    mem[0] = word(3, 0, 5);
    e = model(smp3(8, 3, 0));
    check("oob_model_err", 32'(e.err), 32'(1));
    run_sample(smp3(8, 3, 0), 1, 0, "oob");
    load_s1();
    run_sample(smp3(8, 3, 0), 1, 0, "after_oob");

    // Reset while waiting on the root read, then stray responses.
    lat = 3;
    bus.s_data  = smp3(8, 3, 0);
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrst_sready", 32'(bus.s_ready), 32'(1));
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stray_valid = (i == 4);
      @(posedge clk); #1;
      if (bus.s_ready !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.m_valid !== 1'b0) bad = 1'b1;
    end
    stray_valid = 1'b0;
    check("midrst_idle", 32'(bad), 32'(0));
    check("midrst_result", 32'(bus.m_result), 32'(0));
    check("midrst_leaf", 32'(bus.m_leaf), 32'(0));
    run_sample(smp3(8, 3, 0), 1, 0, "post_rst");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NWORDS; i++)
        mem[i] = word($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      run_sample(smp3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)),
                 $urandom_range(1, 4), $urandom_range(0, 3), $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tree_walk_engine.md
Name: tree_walk_engine

Overview:
Parametrised successor to the fixed 2-level node/leaf logic: walks one sample through a complete binary decision tree of DEPTH levels, then applies the leaf's affine transform. Node and leaf records are fetched from an external SRAM over a request/valid read port with arbitrary latency. Samples enter and results leave through valid/ready handshakes. The block sits between the sample pipeline registers and the downstream scoring stage.

Parameters:
DEPTH, 2, number of internal-node levels (1..8); tree has 2^DEPTH leaves
NUM_FEAT, 4, features per sample
FEAT_W, 8, bits per feature, threshold, mult and offset (unsigned)
FIDX_W, 2, feature-index field width; must satisfy 2^FIDX_W >= NUM_FEAT
ADDR_W, DEPTH+1, SRAM address width (derived)
MEM_W, FIDX_W+2*FEAT_W, SRAM word width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  sample offered
s_ready  out  1  engine idle, can accept a sample
s_data  in  NUM_FEAT*FEAT_W  sample; feature k at [k*FEAT_W +: FEAT_W]
mem_rd_en  out  1  one-cycle read request
mem_addr  out  ADDR_W  read address
mem_rd_valid  in  1  read data valid
mem_rd_data  in  MEM_W  {fidx, hi_field, lo_field}
m_valid  out  1  result available
m_ready  in  1  downstream accepts result
m_result  out  2*FEAT_W  mult*feature + offset
m_leaf  out  DEPTH  leaf index reached
m_err  out  1  a feature index >= NUM_FEAT was used

Behaviour:
- Reset (async, rst_n=0): state IDLE; s_ready=1; mem_rd_en=0; mem_addr=0; m_valid=0; m_result=0; m_leaf=0; m_err=0; sample register cleared.
- States: IDLE, FETCH, WAIT, LEAF_FETCH, LEAF_WAIT, DONE.
- IDLE: s_ready=1. On s_valid: capture s_data, set node index n=0, level=0, clear err, go FETCH.
- FETCH: mem_rd_en=1 for exactly one cycle, mem_addr=n; go WAIT.
- WAIT: hold until mem_rd_valid. Node word: fidx=[MEM_W-1 -: FIDX_W], threshold=lo_field, hi_field ignored. Select feature f=sample[fidx]. n_next=2n+1 if f>threshold, else 2n+2 (equality takes the +2 branch). If level==DEPTH-1 go LEAF_FETCH, else level++ and go FETCH.
- LEAF_FETCH: mem_rd_en=1, mem_addr=n (leaf nodes occupy addresses 2^DEPTH-1 .. 2^(DEPTH+1)-2); go LEAF_WAIT.
- LEAF_WAIT: on mem_rd_valid: leaf word fidx, mult=hi_field, offset=lo_field. Register m_result=mult*sample[fidx]+offset (full 2*FEAT_W, no overflow possible) and m_leaf=n-(2^DEPTH-1). Go DONE.
- DONE: m_valid=1; outputs stable until m_ready. m_valid&&m_ready returns to IDLE, which costs one bubble cycle before the next accept.
- Latency: memory returns valid L>=1 cycles after the request cycle. m_valid rises (DEPTH+1)*(L+1) clock edges after the accepting edge (L=1, DEPTH=2: 6).
- mem_rd_valid outside WAIT/LEAF_WAIT is ignored.
- Out-of-range fidx (>=NUM_FEAT): feature value 0, m_err is set sticky for this sample, and the walk continues.
- s_valid while busy: not accepted; the source must hold it.
- rst_n asserted mid-walk: immediate return to reset values; an in-flight memory response after release is ignored.

Optional Feature:
TREE_PATH_TRACE_EN: when defined, adds output m_path [DEPTH-1:0]. Bit i=1 if level i took the f>threshold (+1) branch. It is registered with m_result, and its reset value is 0. When undefined, the port and its register are absent.

Decomposition:
- Shared header crf_tree_defs.vh: state encodings, word-field offset macros (FIDX_LSB, HI_LSB, LO_LSB), and the leaf-base expression.
- Sub-module leaf_mac: registered mult*feature+offset, parametrised by FEAT_W. It is reused by later leaf-scoring blocks.

Test Plan:
- DEPTH=2, L=1. Sample f0=8. Root {fidx0, thr 4}; node1 {fidx1, thr 9} with f1=3; leaf addr 4 {fidx0, mult 8, off 5} -> m_result=0x45, m_leaf=1, m_valid 6 edges after accept.
- Equality: f0=8, root thr 8 -> path goes to node2 (addr 2). Leaf {mult 8, off 0, f=8} -> m_result=0x40.
- Variable latency L=3 with m_ready held low 4 cycles -> m_valid asserted at edge 12. Outputs stable while stalled; s_ready=0 throughout; s_ready=1 one cycle after the handshake.
- Node with fidx=3, NUM_FEAT=3 -> feature taken as 0, path +1 if thr<0 is false, m_err=1. The next sample shows m_err=0.
- rst_n pulsed low during WAIT, then a stray mem_rd_valid after release -> engine stays IDLE, mem_rd_en=0, m_valid=0.
- TREE_PATH_TRACE_EN defined, first scenario -> m_path=2'b01 (level0 +1, level1 +2).
